// File: rtl/mem_arbiter_pkg.sv
// Shared types and default sizing for the two-requester memory arbiter.
package mem_arbiter_pkg;
  localparam int DEF_DWIDTH  = 32;
  localparam int DEF_AWIDTH  = 16;
  localparam int DEF_TIMEOUT = 16;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} arb_state_e;
endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: the pointer breaks ties, a lone requester always wins.
module rr_pick2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic       gnt,
  output logic       any
);
  assign any = |valid;
  assign gnt = (&valid) ? ptr : valid[1];
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two requesters onto one memory-controller port with a timeout abort
// and a four-phase Ready/Valid handshake back to the winning requester.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DWIDTH  = DEF_DWIDTH,
  parameter int AWIDTH  = DEF_AWIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        Valid,
  input  logic [1:0]        RW,
  input  logic [AWIDTH-1:0] Addr0,
  input  logic [AWIDTH-1:0] Addr1,
  input  logic [DWIDTH-1:0] WData0,
  input  logic [DWIDTH-1:0] WData1,
  output logic [1:0]        Ready,
  output logic [DWIDTH-1:0] RData,
  output logic [1:0]        Err,
  output logic              mValid,
  output logic              mRW,
  output logic [AWIDTH-1:0] mAddr,
  output logic [DWIDTH-1:0] mWData,
  input  logic              mReady,
  input  logic [DWIDTH-1:0] mRData
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] TO_SAT  = CW'(TIMEOUT);

  arb_state_e    state, state_nxt;
  logic          ptr, g, err_q;
  logic          pick, any;
  logic [CW-1:0] cnt;

  rr_pick2 u_pick (.valid(Valid), .ptr(ptr), .gnt(pick), .any(any));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any && !mReady) state_nxt = ISSUE;
      ISSUE:   if (mReady || cnt == TO_LAST) state_nxt = RESP;
      RESP:    if (!Valid[g]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr    <= 1'b0;
      g      <= 1'b0;
      err_q  <= 1'b0;
      cnt    <= '0;
      mRW    <= 1'b1;
      mAddr  <= '0;
      mWData <= '0;
      RData  <= '0;
    end else begin
      unique case (state)
        IDLE: if (any && !mReady) begin
          g      <= pick;
          mRW    <= RW[pick];
          mAddr  <= pick ? Addr1 : Addr0;
          mWData <= pick ? WData1 : WData0;
          cnt    <= '0;
          err_q  <= 1'b0;
          RData  <= '0;
        end
        ISSUE: begin
          if (mReady) begin
            RData <= mRW ? mRData : '0;
          end else if (cnt == TO_LAST) begin
            err_q <= 1'b1;
            RData <= '0;
          end
          if (cnt != TO_SAT) cnt <= cnt + 1'b1;
        end
        // Point at the other requester so a pending peer is never skipped twice.
        RESP: if (!Valid[g]) ptr <= ~g;
        default: ;
      endcase
    end
  end

  assign mValid = (state == ISSUE);
  assign Ready  = (state == RESP) ? (g ? 2'b10 : 2'b01) : 2'b00;
  assign Err    = (state == RESP && err_q) ? (g ? 2'b10 : 2'b01) : 2'b00;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: write, read, contention, timeout, async reset, stability.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  Valid, RW, Ready, Err;
  logic [15:0] Addr0, Addr1, mAddr;
  logic [31:0] WData0, WData1, RData, mWData, mRData;
  logic        mValid, mRW, mReady;
  int checks = 0;
  int errors = 0;

  mem_arbiter #(.DWIDTH(32), .AWIDTH(16), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .Valid(Valid), .RW(RW),
    .Addr0(Addr0), .Addr1(Addr1), .WData0(WData0), .WData1(WData1),
    .Ready(Ready), .RData(RData), .Err(Err),
    .mValid(mValid), .mRW(mRW), .mAddr(mAddr), .mWData(mWData),
    .mReady(mReady), .mRData(mRData)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; Valid = 2'b00; RW = 2'b00;
    Addr0 = '0; Addr1 = '0; WData0 = '0; WData1 = '0;
    mReady = 1'b0; mRData = '0;
    #12;
    chk("rst_ready",  Ready,  2'b00);
    chk("rst_err",    Err,    2'b00);
    chk("rst_mvalid", mValid, 1'b0);
    chk("rst_mrw",    mRW,    1'b1);
    chk("rst_maddr",  mAddr,  16'h0);
    chk("rst_mwdata", mWData, 32'h0);
    chk("rst_rdata",  RData,  32'h0);
    rst_n = 1'b1;

    // single write from requester 0, mReady 3 cycles after mValid
    Valid = 2'b01; RW = 2'b00; Addr0 = 16'h0002; WData0 = 32'hDEADBEEF;
    tick();
    chk("wr_mvalid", mValid, 1'b1);
    chk("wr_maddr",  mAddr,  16'h0002);
    chk("wr_mwdata", mWData, 32'hDEADBEEF);
    chk("wr_mrw",    mRW,    1'b0);
    Addr0 = 16'h00FF; WData0 = 32'h0;
    tick();
    chk("stab_maddr",  mAddr,  16'h0002);
    chk("stab_mwdata", mWData, 32'hDEADBEEF);
    tick(); tick();
    chk("wr_wait_ready", Ready, 2'b00);
    mReady = 1'b1;
    tick();
    mReady = 1'b0;
    chk("wr_ready",  Ready, 2'b01);
    chk("wr_err",    Err,   2'b00);
    chk("wr_rdata",  RData, 32'h0);
    chk("wr_mvalid_resp", mValid, 1'b0);
    tick();
    chk("wr_ready_hold", Ready, 2'b01);
    Valid = 2'b00;
    tick();
    chk("wr_ready_drop", Ready, 2'b00);

    // single read from requester 1
    Valid = 2'b10; RW = 2'b10; Addr1 = 16'h0001;
    tick();
    chk("rd_maddr", mAddr, 16'h0001);
    chk("rd_mrw",   mRW,   1'b1);
    mReady = 1'b1; mRData = 32'h12345678;
    tick();
    mReady = 1'b0; mRData = 32'h0;
    chk("rd_ready", Ready, 2'b10);
    chk("rd_rdata", RData, 32'h12345678);
    tick(); tick();
    chk("rd_ready_hold", Ready, 2'b10);
    chk("rd_rdata_hold", RData, 32'h12345678);
    Valid = 2'b00;
    tick();
    chk("rd_ready_drop", Ready, 2'b00);

    // contention from reset
    rst_n = 1'b0;
    Valid = 2'b11; RW = 2'b11; Addr0 = 16'h0010; Addr1 = 16'h0020;
    #3 rst_n = 1'b1;
    tick();
    chk("ct1_maddr", mAddr, 16'h0010);
    mReady = 1'b1; mRData = 32'hAAAA0000;
    tick();
    mReady = 1'b0;
    chk("ct1_ready", Ready, 2'b01);
    chk("ct1_rdata", RData, 32'hAAAA0000);
    Valid = 2'b10;
    tick();
    Valid = 2'b11;
    tick();
    chk("ct2_maddr", mAddr, 16'h0020);
    mReady = 1'b1; mRData = 32'hBBBB1111;
    tick();
    mReady = 1'b0;
    chk("ct2_ready", Ready, 2'b10);
    chk("ct2_rdata", RData, 32'hBBBB1111);
    Valid = 2'b01;
    tick();
    Valid = 2'b11;
    tick();
    chk("ct3_maddr", mAddr, 16'h0010);
    mReady = 1'b1; mRData = 32'hCCCC2222;
    tick();
    mReady = 1'b0;
    chk("ct3_ready", Ready, 2'b01);
    Valid = 2'b00;
    tick();

    // timeout: requester 0 read, mReady never rises
    Valid = 2'b01; RW = 2'b01;
    tick();
    chk("to_mvalid", mValid, 1'b1);
    for (int i = 0; i < 15; i++) tick();
    chk("to_ready_early", Ready, 2'b00);
    chk("to_mvalid_late", mValid, 1'b1);
    tick();
    chk("to_ready", Ready, 2'b01);
    chk("to_err",   Err,   2'b01);
    chk("to_rdata", RData, 32'h0);
    Valid = 2'b00;
    tick();
    chk("to_err_drop", Err, 2'b00);

    // async reset mid-ISSUE; pointer currently favours requester 1
    Valid = 2'b10; RW = 2'b00; Addr1 = 16'h0033;
    tick();
    chk("ar_mvalid_pre", mValid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_mvalid", mValid, 1'b0);
    chk("ar_ready",  Ready,  2'b00);
    chk("ar_err",    Err,    2'b00);
    chk("ar_maddr",  mAddr,  16'h0);
    Valid = 2'b11;
    #10 rst_n = 1'b1;
    tick();
    chk("ar_regrant", mAddr, 16'h0010);
    chk("ar_regrant_v", mValid, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
